seg_scan_ctrl: RTL

//   Time-multiplexing scan controller for the 8-digit 7-segment display.

---
 rtl/seg_scan_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed 7-segment display: holds one nibble per digit,
// lights one digit at a time with an optional all-dark guard gap between digits.
module seg_scan_ctrl #(
  parameter int DIGITS          = 8,
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [7:0] dig_mask,
  output logic [2:0] sel,
  output logic [3:0] nibble,
  output logic [7:0] an,
  output logic       blank,
  output logic       frame_done
);

  localparam int MAX_T = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
  localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [2:0]    SEL_LAST = 3'(DIGITS - 1);
  localparam logic [CW-1:0] T_LAST   = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] B_LAST   = CW'((BLANK_TICKS > 0) ? (BLANK_TICKS - 1) : 0);

  typedef enum logic [1:0] {IDLE, ON, GUARD} state_t;

  state_t        state_reg, state_next;
  logic [2:0]    sel_reg, sel_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [7:0]    an_reg, an_next;
  logic          frame_done_reg;
  logic          wrap;

  // Always 8 entries so any 3-bit index is in range; entries >= DIGITS stay zero.
  logic [3:0] digit_mem [8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) digit_mem[i] <= 4'h0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_en && (wr_addr == 3'(i)) && (i < DIGITS)) digit_mem[i] <= wr_data;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      sel_reg        <= 3'd0;
      cnt_reg        <= '0;
      an_reg         <= 8'hFF;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      cnt_reg        <= cnt_next;
      an_reg         <= an_next;
      frame_done_reg <= wrap;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    wrap       = 1'b0;
    if (!en) begin
      state_next = IDLE;
      sel_next   = 3'd0;
      cnt_next   = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          state_next = ON;
          sel_next   = 3'd0;
          cnt_next   = '0;
        end
        ON: begin
          if (cnt_reg == T_LAST) begin
            cnt_next = '0;
            if (BLANK_TICKS > 0) begin
              state_next = GUARD;
            end else begin
              wrap     = (sel_reg == SEL_LAST);
              sel_next = wrap ? 3'd0 : sel_reg + 3'd1;
            end
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        GUARD: begin
          if (cnt_reg == B_LAST) begin
            cnt_next   = '0;
            state_next = ON;
            wrap       = (sel_reg == SEL_LAST);
            sel_next   = wrap ? 3'd0 : sel_reg + 3'd1;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        default: begin
          state_next = IDLE;
          sel_next   = 3'd0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Anode drive is registered from the next state so the first lit cycle follows en directly
  always_comb begin
    an_next = 8'hFF;
    if (state_next == ON && dig_mask[sel_next]) an_next = ~(8'b1 << sel_next);
  end

  assign sel        = sel_reg;
  assign an         = an_reg;
  assign blank      = (an_reg == 8'hFF);
  assign frame_done = frame_done_reg;
  assign nibble     = digit_mem[sel_reg];

endmodule
